// File: rtl/lc4_iter_muldiv_pkg.sv
// Shared encodings for the LC4 iterative multiply/divide unit.
package lc4_iter_muldiv_pkg;

    // Operation select carried on i_op.
    typedef enum logic [1:0] {
        OpMul = 2'b00,
        OpDiv = 2'b01,
        OpMod = 2'b10,
        OpRsv = 2'b11
    } op_e;

    // Control FSM states.
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StBusy = 2'b01,
        StDone = 2'b10
    } state_e;

    // Requests that complete without iterating: reserved op, or divide/modulo by zero.
    function automatic logic is_shortcut(input op_e op, input logic b_zero);
        return (op == OpRsv) || (((op == OpDiv) || (op == OpMod)) && b_zero);
    endfunction

endpackage

// File: rtl/lc4_muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring-divide step.
// Multiply: a = multiplicand (shifts left), x = multiplier (shifts right), acc = product.
// Divide:   a = divisor (fixed), x = dividend shifting out / quotient shifting in,
//           acc = partial remainder.
module lc4_muldiv_step #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             is_mul_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] acc_i,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] x_o,
    output logic [WIDTH-1:0] acc_o
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] addend;

    // Select and compute the multiply or divide step.
    always_comb begin
        shifted = {acc_i, x_i[WIDTH-1]};
        addend  = x_i[0] ? a_i : '0;
        a_o     = a_i;
        x_o     = x_i;
        acc_o   = acc_i;
        if (is_mul_i) begin
            // Product kept modulo 2^WIDTH; carries out of the top bit are dropped.
            acc_o = acc_i + addend;
            a_o   = a_i << 1;
            x_o   = x_i >> 1;
        end else if (shifted >= {1'b0, a_i}) begin
            // Remainder < divisor afterwards, so the low WIDTH bits hold it exactly.
            acc_o = shifted[WIDTH-1:0] - a_i;
            x_o   = {x_i[WIDTH-2:0], 1'b1};
        end else begin
            acc_o = shifted[WIDTH-1:0];
            x_o   = {x_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/lc4_iter_muldiv.sv
// Multi-cycle unsigned MUL/DIV/MOD with valid/ready handshakes, flush and backpressure.
// WIDTH must be >= 4 and a multiple of BITS_PER_CYCLE (1, 2 or 4).
module lc4_iter_muldiv
    import lc4_iter_muldiv_pkg::*;
#(
    parameter int unsigned WIDTH          = 16,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_busy
);

    localparam int unsigned Iters   = WIDTH / BITS_PER_CYCLE;
    localparam int unsigned CntW    = $clog2(Iters + 1);
    localparam logic [CntW-1:0] CntInit = CntW'(Iters);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    state_e           state_q, state_d;
    op_e              op_q, op_d, req_op;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, x_q, x_d, acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] a_nxt, x_nxt, acc_nxt, op_result;
    logic             accept, is_mul;

    assign req_op = op_e'(i_op);
    assign is_mul = (op_q == OpMul);

    // Chain BITS_PER_CYCLE step slices; each slice feeds the next within one cycle.
    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
        logic [WIDTH-1:0] a_in, x_in, acc_in, a_out, x_out, acc_out;
        if (i == 0) begin : g_head
            assign a_in   = a_q;
            assign x_in   = x_q;
            assign acc_in = acc_q;
        end else begin : g_link
            assign a_in   = g_step[i-1].a_out;
            assign x_in   = g_step[i-1].x_out;
            assign acc_in = g_step[i-1].acc_out;
        end
        lc4_muldiv_step #(
            .WIDTH(WIDTH)
        ) u_step (
            .is_mul_i(is_mul),
            .a_i     (a_in),
            .x_i     (x_in),
            .acc_i   (acc_in),
            .a_o     (a_out),
            .x_o     (x_out),
            .acc_o   (acc_out)
        );
    end

    assign a_nxt   = g_step[BITS_PER_CYCLE-1].a_out;
    assign x_nxt   = g_step[BITS_PER_CYCLE-1].x_out;
    assign acc_nxt = g_step[BITS_PER_CYCLE-1].acc_out;

    // Quotient lives in x; product and remainder live in acc.
    always_comb begin
        op_result = acc_nxt;
        if (op_q == OpDiv) begin
            op_result = x_nxt;
        end
    end

    // Handshake outputs decoded from the current state.
    always_comb begin
        o_ready  = (state_q == StIdle) || ((state_q == StDone) && i_ready);
        o_valid  = (state_q == StDone);
        o_busy   = (state_q == StBusy);
        o_result = result_q;
        accept   = i_valid && o_ready && !i_flush;
    end

    // Next-state logic: flush wins, then iteration/handshake, then a new accept.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        x_d      = x_q;
        acc_d    = acc_q;
        result_d = result_q;
        if (i_flush) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StBusy: begin
                    a_d   = a_nxt;
                    x_d   = x_nxt;
                    acc_d = acc_nxt;
                    cnt_d = cnt_q - CntOne;
                    if (cnt_q == CntOne) begin
                        state_d  = StDone;
                        result_d = op_result;
                    end
                end
                StDone: begin
                    if (i_ready) begin
                        state_d = StIdle;
                    end
                end
                default: ;
            endcase
            if (accept) begin
                op_d  = req_op;
                acc_d = '0;
                cnt_d = CntInit;
                // Multiplier sits in x; for division the dividend sits in x, divisor in a.
                if (req_op == OpMul) begin
                    a_d = i_a;
                    x_d = i_b;
                end else begin
                    a_d = i_b;
                    x_d = i_a;
                end
                if (is_shortcut(req_op, i_b == '0)) begin
                    state_d  = StDone;
                    result_d = '0;
                end else begin
                    state_d = StBusy;
                end
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            op_q     <= OpMul;
            cnt_q    <= '0;
            a_q      <= '0;
            x_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            x_q      <= x_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_lc4_iter_muldiv.sv
// Self-checking bench for lc4_iter_muldiv at WIDTH=16/BPC=1 and WIDTH=32/BPC=4.
module tb_lc4_iter_muldiv;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        f16, v16, r16;
    logic [1:0]  op16;
    logic [15:0] a16, b16;
    logic        rdy16, val16, busy16;
    logic [15:0] res16;

    logic        f32, v32, r32;
    logic [1:0]  op32;
    logic [31:0] a32, b32;
    logic        rdy32, val32, busy32;
    logic [31:0] res32;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [15:0] last16 = '0;

    lc4_iter_muldiv #(.WIDTH(16), .BITS_PER_CYCLE(1)) dut16 (
        .clk(clk), .rst(rst), .i_flush(f16), .i_valid(v16), .o_ready(rdy16), .i_op(op16),
        .i_a(a16), .i_b(b16), .o_valid(val16), .i_ready(r16), .o_result(res16),
        .o_busy(busy16)
    );

    lc4_iter_muldiv #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut32 (
        .clk(clk), .rst(rst), .i_flush(f32), .i_valid(v32), .o_ready(rdy32), .i_op(op32),
        .i_a(a32), .i_b(b32), .o_valid(val32), .i_ready(r32), .o_result(res32),
        .o_busy(busy32)
    );

    // Reference: plain unsigned arithmetic, truncated to w bits; x/0 and reserved give 0.
    function automatic logic [31:0] ref_calc(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input int w);
        longint unsigned la, lb, mask, r;
        la   = 64'(a);
        lb   = 64'(b);
        mask = (64'd1 << w) - 64'd1;
        case (op)
            2'b00:   r = la * lb;
            2'b01:   r = (lb == 0) ? 64'd0 : la / lb;
            2'b10:   r = (lb == 0) ? 64'd0 : la % lb;
            default: r = 64'd0;
        endcase
        return 32'(r & mask);
    endfunction

    function automatic int exp_lat(input logic [1:0] op, input logic [31:0] b, input int n);
        if (op == 2'b11 || (op != 2'b00 && b == 0)) return 0;
        return n;
    endfunction

    // Counts edges after the accept edge until o_valid is seen (bounded).
    task automatic wait_valid16(output int edges);
        edges = 0;
        while (val16 !== 1'b1 && edges < 100) begin
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic wait_valid32(output int edges);
        edges = 0;
        while (val32 !== 1'b1 && edges < 100) begin
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic run16(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp, input string name);
        int edges;
        int lat;
        lat = exp_lat(op, 32'(b), 16);
        @(negedge clk);
        v16 = 1'b1; op16 = op; a16 = a; b16 = b;
        total_cnt++;
        if (rdy16 !== 1'b1) $display("FAIL %s ready: got %b want 1", name, rdy16);
        else pass_cnt++;
        @(posedge clk);
        @(negedge clk);
        // Operands change after acceptance must not disturb the operation.
        v16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
        wait_valid16(edges);
        total_cnt++;
        if (edges !== lat) $display("FAIL %s latency: got %0d want %0d", name, edges, lat);
        else pass_cnt++;
        total_cnt++;
        if (res16 !== exp) $display("FAIL %s result: got %h want %h", name, res16, exp);
        else pass_cnt++;
        last16 = exp;
        @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if (val16 !== 1'b0) $display("FAIL %s drain: o_valid got %b want 0", name, val16);
        else pass_cnt++;
    endtask

    task automatic run32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string name);
        int edges;
        int lat;
        lat = exp_lat(op, b, 8);
        @(negedge clk);
        v32 = 1'b1; op32 = op; a32 = a; b32 = b;
        @(posedge clk);
        @(negedge clk);
        v32 = 1'b0; a32 = $urandom; b32 = $urandom;
        wait_valid32(edges);
        total_cnt++;
        if (edges !== lat) $display("FAIL %s latency: got %0d want %0d", name, edges, lat);
        else pass_cnt++;
        total_cnt++;
        if (res32 !== exp) $display("FAIL %s result: got %h want %h", name, res32, exp);
        else pass_cnt++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        total_cnt++;
        if (val16 !== 1'b0 || busy16 !== 1'b0 || res16 !== 16'h0)
            $display("FAIL reset16: valid %b busy %b result %h want 0 0 0", val16, busy16, res16);
        else pass_cnt++;
        total_cnt++;
        if (val32 !== 1'b0 || busy32 !== 1'b0 || res32 !== 32'h0)
            $display("FAIL reset32: valid %b busy %b result %h want 0 0 0", val32, busy32, res32);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total_cnt++;
        if (rdy16 !== 1'b1 || rdy32 !== 1'b1)
            $display("FAIL reset_ready: got %b %b want 1 1", rdy16, rdy32);
        else pass_cnt++;
    endtask

    task automatic test_directed16();
        logic [1:0]  ops [10] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10,
                                 2'b11};
        logic [15:0] as  [10] = '{16'h1234, 16'hFFFF, 16'h0064, 16'h0064, 16'hFFFF, 16'h0003,
                                 16'h0003, 16'h0005, 16'h0005, 16'h1234};
        logic [15:0] bs  [10] = '{16'h0010, 16'hFFFF, 16'h0007, 16'h0007, 16'h0001, 16'h0009,
                                 16'h0009, 16'h0000, 16'h0000, 16'h5678};
        logic [15:0] ex  [10] = '{16'h2340, 16'h0001, 16'h000E, 16'h0002, 16'hFFFF, 16'h0000,
                                 16'h0003, 16'h0000, 16'h0000, 16'h0000};
        for (int i = 0; i < 10; i++) begin
            run16(ops[i], as[i], bs[i], ex[i], $sformatf("dir16_%0d", i));
        end
    endtask

    task automatic test_random16();
        logic [1:0]  op;
        logic [15:0] a, b;
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = 16'($urandom);
            if ($urandom_range(0, 7) == 0) b = 16'h0;
            else if ($urandom_range(0, 1) == 1) b = 16'($urandom_range(1, 255));
            else b = 16'($urandom);
            run16(op, a, b, 16'(ref_calc(op, 32'(a), 32'(b), 16)), $sformatf("rand16_%0d", i));
        end
    endtask

    task automatic test_back_to_back();
        int edges;
        r16 = 1'b0;
        @(negedge clk);
        v16 = 1'b1; op16 = 2'b00; a16 = 16'h1234; b16 = 16'h0010;
        @(posedge clk);
        @(negedge clk);
        v16 = 1'b0;
        wait_valid16(edges);
        total_cnt++;
        if (edges !== 16 || res16 !== 16'h2340)
            $display("FAIL bp_first: edges %0d result %h want 16 2340", edges, res16);
        else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total_cnt++;
            if (val16 !== 1'b1 || res16 !== 16'h2340 || rdy16 !== 1'b0)
                $display("FAIL bp_hold_%0d: valid %b result %h ready %b want 1 2340 0",
                         i, val16, res16, rdy16);
            else pass_cnt++;
        end
        r16 = 1'b1; v16 = 1'b1; op16 = 2'b00; a16 = 16'h0003; b16 = 16'h0005;
        #1;
        total_cnt++;
        if (rdy16 !== 1'b1) $display("FAIL b2b_ready: got %b want 1", rdy16);
        else pass_cnt++;
        @(posedge clk);
        @(negedge clk);
        v16 = 1'b0;
        total_cnt++;
        if (val16 !== 1'b0 || busy16 !== 1'b1)
            $display("FAIL b2b_issue: valid %b busy %b want 0 1", val16, busy16);
        else pass_cnt++;
        wait_valid16(edges);
        total_cnt++;
        if (edges !== 16 || res16 !== 16'h000F)
            $display("FAIL b2b_result: edges %0d result %h want 16 000f", edges, res16);
        else pass_cnt++;
        last16 = 16'h000F;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_flush();
        int seen;
        int edges;
        // Flush at the seventh BUSY cycle.
        @(negedge clk);
        v16 = 1'b1; op16 = 2'b00; a16 = 16'h00FF; b16 = 16'h0101;
        @(posedge clk);
        @(negedge clk);
        v16 = 1'b0;
        repeat (6) @(negedge clk);
        total_cnt++;
        if (busy16 !== 1'b1) $display("FAIL flush_pre: busy got %b want 1", busy16);
        else pass_cnt++;
        f16 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        f16 = 1'b0;
        total_cnt++;
        if (busy16 !== 1'b0 || val16 !== 1'b0 || rdy16 !== 1'b1 || res16 !== last16)
            $display("FAIL flush_busy: busy %b valid %b ready %b result %h want 0 0 1 %h",
                     busy16, val16, rdy16, res16, last16);
        else pass_cnt++;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (val16 === 1'b1) seen = 1;
        end
        total_cnt++;
        if (seen !== 0) $display("FAIL flush_quiet: o_valid seen %0d want 0", seen);
        else pass_cnt++;
        // Flush coincident with accept drops the request.
        v16 = 1'b1; f16 = 1'b1; op16 = 2'b01; a16 = 16'h0064; b16 = 16'h0007;
        @(posedge clk);
        @(negedge clk);
        v16 = 1'b0; f16 = 1'b0;
        total_cnt++;
        if (busy16 !== 1'b0 || val16 !== 1'b0 || rdy16 !== 1'b1)
            $display("FAIL flush_accept: busy %b valid %b ready %b want 0 0 1",
                     busy16, val16, rdy16);
        else pass_cnt++;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (val16 === 1'b1) seen = 1;
        end
        total_cnt++;
        if (seen !== 0) $display("FAIL flush_accept_quiet: o_valid seen %0d want 0", seen);
        else pass_cnt++;
        // Flush in DONE under backpressure: valid drops, result held.
        r16 = 1'b0;
        v16 = 1'b1; op16 = 2'b00; a16 = 16'h0007; b16 = 16'h0009;
        @(posedge clk);
        @(negedge clk);
        v16 = 1'b0;
        wait_valid16(edges);
        f16 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        f16 = 1'b0; r16 = 1'b1;
        total_cnt++;
        if (val16 !== 1'b0 || res16 !== 16'h003F || rdy16 !== 1'b1)
            $display("FAIL flush_done: valid %b result %h ready %b want 0 003f 1",
                     val16, res16, rdy16);
        else pass_cnt++;
        last16 = 16'h003F;
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge clk);
        v16 = 1'b1; op16 = 2'b00; a16 = 16'h1111; b16 = 16'h0003;
        @(posedge clk);
        @(negedge clk);
        v16 = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total_cnt++;
        if (val16 !== 1'b0 || busy16 !== 1'b0 || res16 !== 16'h0)
            $display("FAIL reset_mid: valid %b busy %b result %h want 0 0 0",
                     val16, busy16, res16);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total_cnt++;
        if (rdy16 !== 1'b1) $display("FAIL reset_mid_ready: got %b want 1", rdy16);
        else pass_cnt++;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (val16 === 1'b1) seen = 1;
        end
        total_cnt++;
        if (seen !== 0) $display("FAIL reset_mid_quiet: o_valid seen %0d want 0", seen);
        else pass_cnt++;
        last16 = 16'h0;
    endtask

    task automatic test_w32();
        logic [1:0]  op;
        logic [31:0] a, b;
        run32(2'b01, 32'hDEADBEEF, 32'h00010000, 32'h0000DEAD, "w32_div");
        run32(2'b10, 32'hDEADBEEF, 32'h00010000, 32'h0000BEEF, "w32_mod");
        run32(2'b10, 32'h12345678, 32'h0, 32'h0, "w32_mod0");
        for (int i = 0; i < 12; i++) begin
            op = 2'($urandom_range(0, 2));
            a  = $urandom;
            b  = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 70000)) : $urandom;
            run32(op, a, b, ref_calc(op, a, b, 32), $sformatf("rand32_%0d", i));
        end
    endtask

    initial begin
        f16 = 1'b0; v16 = 1'b0; r16 = 1'b1; op16 = 2'b00; a16 = '0; b16 = '0;
        f32 = 1'b0; v32 = 1'b0; r32 = 1'b1; op32 = 2'b00; a32 = '0; b32 = '0;
        test_reset();
        test_directed16();
        test_random16();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_w32();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
